imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the decode stage. Decodes the

---
 rtl/imm_gen_pipe.sv | 195 +++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined immediate generator for the decode stage. The opcode selects the
//   immediate format (R/I/S/B/U/J). The block produces the sign-extended XLEN-bit
//   immediate, a format code and an illegal-opcode flag. One registered output
//   stage is backed by a skid slot, so the input side never sees a combinational
//   path from out_ready. Consumer stalls are absorbed at full throughput.
//
// Parameters
//   XLEN        immediate width, 32 or 64 (64 also accepts OP-IMM-32 / OP-32)
//   SHAMT_ZEXT  1: OP-IMM shifts return the zero-extended shift amount only
//   CNT_W       width of the saturating illegal-opcode counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   flush        synchronous flush, drops every held entry
//   in_valid     instruction valid
//   in_ready     block can take an instruction this cycle
//   instr        raw 32-bit instruction word
//   out_valid    imm/fmt/illegal are valid
//   out_ready    consumer takes the output this cycle
//   imm          sign-extended immediate
//   fmt          0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   illegal      opcode not recognised
//   illegal_cnt  saturating count of illegal entries handed to the consumer
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     raw;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic            skid_ill;
  logic            in_xfer;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Decode the opcode into a 32-bit immediate. Every format's top bit already
  // sits at bit 31 after this step, so widening to XLEN is one sign extension.
  // Shift immediates keep only the shamt field, so funct7 never leaks into imm.
  always_comb begin
    raw     = 32'd0;
    dec_fmt = FMT_ILL;
    dec_ill = 1'b1;
    case (opcode)
      7'b0010011: begin
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
        raw     = {{20{instr[31]}}, instr[31:20]};
        if (SHAMT_ZEXT && (funct3 == 3'b001 || funct3 == 3'b101)) begin
          if (XLEN == 64) raw = {26'd0, instr[25:20]};
          else            raw = {27'd0, instr[24:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
        raw     = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          dec_ill = 1'b0;
          raw     = {{20{instr[31]}}, instr[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_ill = 1'b0;
        raw     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_ill = 1'b0;
        raw     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_ill = 1'b0;
        raw     = {instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_ill = 1'b0;
        raw     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_R;
          dec_ill = 1'b0;
        end
      end
      default: begin
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
      end
    endcase
    dec_imm = XLEN'($signed(raw));
  end

  // The skid slot is a register, so in_ready never depends on out_ready.
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;

  // Output register plus skid slot. The output register reloads whenever it is
  // empty or being consumed. The skid slot drains into it first, which keeps
  // entries in order. A transfer that arrives while the output is stalled
  // parks in the skid slot. A flush empties both; in_ready rises again because
  // the skid slot is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      imm        <= '0;
      fmt        <= 3'd0;
      illegal    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= 3'd0;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        imm        <= skid_imm;
        fmt        <= skid_fmt;
        illegal    <= skid_ill;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        imm       <= dec_imm;
        fmt       <= dec_fmt;
        illegal   <= dec_ill;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_ill   <= dec_ill;
    end
  end

  // Count illegal entries as the consumer takes them. The counter sticks at its
  // maximum value. A flush leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Drives an XLEN=32 instance (CNT_W=2) and an XLEN=64 instance (CNT_W=16)
//   from the same inputs. Expected immediates are hand-decoded in the vector
//   table. A small occupancy model tracks in_ready/out_valid under stalls.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32;
    logic [2:0]  fmt64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int   checks;
  int   errors;
  vec_t vecs [14];

  imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1'b1), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
    .fmt(fmt32), .illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b1), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .fmt(fmt64), .illegal(ill64), .illegal_cnt(cnt64)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a wedged run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] i, input logic [63:0] e32, input logic [63:0] e64,
                              input logic [2:0] f32, input logic [2:0] f64,
                              input logic l32, input logic l64);
    vec_t v;
    v.instr = i; v.imm32 = e32; v.imm64 = e64;
    v.fmt32 = f32; v.fmt64 = f64; v.ill32 = l32; v.ill64 = l64;
    return v;
  endfunction

  // Drive the inputs; the caller steps the clock afterwards.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy,
                               input logic fl, input logic rn);
    in_valid  = v;
    instr     = ins;
    out_ready = rdy;
    flush     = fl;
    rst_n     = rn;
  endtask

  // Step one clock and sample 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int i, input string tag);
    checkOutput($sformatf("%s[%0d].imm32", tag, i), 64'(imm32), vecs[i].imm32);
    checkOutput($sformatf("%s[%0d].fmt32", tag, i), 64'(fmt32), 64'(vecs[i].fmt32));
    checkOutput($sformatf("%s[%0d].ill32", tag, i), 64'(ill32), 64'(vecs[i].ill32));
    checkOutput($sformatf("%s[%0d].imm64", tag, i), imm64, vecs[i].imm64);
    checkOutput($sformatf("%s[%0d].fmt64", tag, i), 64'(fmt64), 64'(vecs[i].fmt64));
    checkOutput($sformatf("%s[%0d].ill64", tag, i), 64'(ill64), 64'(vecs[i].ill64));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".out_valid32"}, 64'(out_valid32), 64'd0);
    checkOutput({tag, ".in_ready32"},  64'(in_ready32),  64'd1);
    checkOutput({tag, ".imm32"},       64'(imm32),       64'd0);
    checkOutput({tag, ".fmt32"},       64'(fmt32),       64'd0);
    checkOutput({tag, ".ill32"},       64'(ill32),       64'd0);
    checkOutput({tag, ".cnt32"},       64'(cnt32),       64'd0);
    checkOutput({tag, ".out_valid64"}, 64'(out_valid64), 64'd0);
    checkOutput({tag, ".in_ready64"},  64'(in_ready64),  64'd1);
    checkOutput({tag, ".imm64"},       imm64,            64'd0);
    checkOutput({tag, ".cnt64"},       64'(cnt64),       64'd0);
  endtask

  // Main test sequence: reset, vector table, stall pattern, flush, counter
  // saturation, and finally a reset while the skid slot is occupied.
  initial begin
    int sent, got, occ;
    logic acc, del;
    logic [3:0] pat;

    checks = 0;
    errors = 0;

    vecs[0]  = mk(32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 3'd1, 1'b0, 1'b0); // addi -1
    vecs[1]  = mk(32'hFE209EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 3'd3, 1'b0, 1'b0); // bne -4
    vecs[2]  = mk(32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 3'd4, 1'b0, 1'b0); // lui
    vecs[3]  = mk(32'h40505093, 64'd5,         64'd5,                   3'd1, 3'd1, 1'b0, 1'b0); // srai 5
    vecs[4]  = mk(32'h0000007F, 64'd0,         64'd0,                   3'd7, 3'd7, 1'b1, 1'b1); // illegal
    vecs[5]  = mk(32'hFE20AC23, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 3'd2, 1'b0, 1'b0); // sw -8
    vecs[6]  = mk(32'hFFDFF06F, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 3'd5, 1'b0, 1'b0); // jal -4
    vecs[7]  = mk(32'h002081B3, 64'd0,         64'd0,                   3'd0, 3'd0, 1'b0, 1'b0); // add
    vecs[8]  = mk(32'h12345097, 64'h1234_5000, 64'h1234_5000,           3'd4, 3'd4, 1'b0, 1'b0); // auipc
    vecs[9]  = mk(32'h7FF00083, 64'h7FF,       64'h7FF,                 3'd1, 3'd1, 1'b0, 1'b0); // lb +2047
    vecs[10] = mk(32'hFFF0009B, 64'd0,         64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 3'd1, 1'b1, 1'b0); // addiw
    vecs[11] = mk(32'h002080BB, 64'd0,         64'd0,                   3'd7, 3'd0, 1'b1, 1'b0); // addw
    vecs[12] = mk(32'hFFF09093, 64'h1F,        64'h3F,                  3'd1, 3'd1, 1'b0, 1'b0); // slli, funct7 set
    vecs[13] = mk(32'h800080E7, 64'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 3'd1, 1'b0, 1'b0); // jalr -2048

    // Reset.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick;
    tick;
    checkResetState("reset");

    // Table pass at full throughput: each entry appears exactly one cycle later.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 1'b1, 1'b0, 1'b1);
      tick;
      checkOutput($sformatf("table[%0d].out_valid", i), 64'(out_valid32), 64'd1);
      checkOutput($sformatf("table[%0d].in_ready", i),  64'(in_ready32),  64'd1);
      checkVec(i, "table");
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    tick;
    checkOutput("table.drain_valid", 64'(out_valid32), 64'd0);
    checkOutput("table.cnt32_sat", 64'(cnt32), 64'd3);
    checkOutput("table.cnt64",     64'(cnt64), 64'd1);

    // Back-to-back entries while out_ready cycles 1,0,0,1.
    pat  = 4'b1001;
    sent = 0;
    got  = 0;
    occ  = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      applyStimulus(sent < 8, vecs[(sent < 8) ? sent : 0].instr, pat[cyc % 4], 1'b0, 1'b1);
      checkOutput($sformatf("stall.c%0d.in_ready32", cyc), 64'(in_ready32), 64'(occ < 2));
      checkOutput($sformatf("stall.c%0d.in_ready64", cyc), 64'(in_ready64), 64'(occ < 2));
      checkOutput($sformatf("stall.c%0d.out_valid", cyc), 64'(out_valid32), 64'(occ > 0));
      acc = in_valid && in_ready32;
      del = out_valid32 && out_ready;
      if (del) begin
        checkVec(got, "stall");
        got++;
      end
      if (acc) sent++;
      tick;
      occ = occ + int'(acc) - int'(del);
    end
    checkOutput("stall.delivered", 64'(got), 64'd8);

    // Fill the skid slot, hold it, then flush.
    applyStimulus(1'b1, vecs[0].instr, 1'b0, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, vecs[1].instr, 1'b0, 1'b0, 1'b1);
    tick;
    checkOutput("full.in_ready",  64'(in_ready32),  64'd0);
    checkOutput("full.out_valid", 64'(out_valid32), 64'd1);
    checkVec(0, "full");
    applyStimulus(1'b1, vecs[2].instr, 1'b0, 1'b0, 1'b1);
    tick;
    checkOutput("hold.in_ready", 64'(in_ready32), 64'd0);
    checkVec(0, "hold");
    applyStimulus(1'b1, vecs[3].instr, 1'b1, 1'b1, 1'b1);
    tick;
    checkOutput("flush.out_valid32", 64'(out_valid32), 64'd0);
    checkOutput("flush.out_valid64", 64'(out_valid64), 64'd0);
    checkOutput("flush.in_ready32",  64'(in_ready32),  64'd1);
    applyStimulus(1'b1, vecs[4].instr, 1'b1, 1'b1, 1'b1);
    tick;
    checkOutput("flush2.out_valid", 64'(out_valid32), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    tick;
    checkOutput("flush.no_ghost", 64'(out_valid32), 64'd0);
    applyStimulus(1'b1, vecs[5].instr, 1'b1, 1'b0, 1'b1);
    tick;
    checkOutput("after_flush.out_valid", 64'(out_valid32), 64'd1);
    checkVec(5, "after_flush");
    checkOutput("after_flush.cnt32", 64'(cnt32), 64'd3);

    // Counter saturation on a fresh start: 4 illegal entries, CNT_W=2.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick;
    checkOutput("cnt.reset", 64'(cnt32), 64'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b1);
      tick;
    end
    checkOutput("cnt.three32", 64'(cnt32), 64'd3);
    checkOutput("cnt.three64", 64'(cnt64), 64'd3);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    tick;
    checkOutput("cnt.sat32",  64'(cnt32), 64'd3);
    checkOutput("cnt.four64", 64'(cnt64), 64'd4);

    // Reset while the skid slot is full; it beats flush and the pending transfer.
    applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, vecs[1].instr, 1'b0, 1'b0, 1'b1);
    tick;
    checkOutput("midrst.skid_full", 64'(in_ready32), 64'd0);
    applyStimulus(1'b1, vecs[2].instr, 1'b1, 1'b1, 1'b0);
    tick;
    checkResetState("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
